bulk_sync_fifo: RTL and testbench
=================================

Name: bulk_sync_fifo

Overview:
Parametrised single-clock FIFO for the USB-to-SD bulk-transfer datapath. It generalises the fixed 8-bit byte FIFO in three ways: width and depth are configurable, it reports an occupancy count and programmable almost-full/almost-empty flags, and it has sticky overflow/underflow error flags. It also supports a synchronous flush and an optional first-word-fall-through read mode. It buffers bulk packet payload between the USB endpoint logic and the SD block-write engine.

Parameters:
DATA_W, 8, data word width in bits (1 to 64).
DEPTH, 64, number of entries; power of 2, at least 4.
AF_THRESH, 60, almost_full asserts when count >= AF_THRESH (1 to DEPTH).
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH (0 to DEPTH-1).
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
n_rst  in  1  synchronous active-low reset.
clear  in  1  synchronous flush; empties the FIFO and clears the error flags.
w_enable  in  1  write request.
w_data  in  DATA_W  write data.
r_enable  in  1  read (pop) request.
r_data  out  DATA_W  read data.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_THRESH.
almost_empty  out  1  count <= AE_THRESH.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky; a write was attempted while full and no read was accepted in the same cycle.
underflow  out  1  sticky; a read was attempted while empty.

Behaviour:
- Reset: the design samples n_rst=0 at a clock edge (synchronous, active-low).
  - wr_ptr, rd_ptr and count go to 0.
  - Flags: empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - r_data goes to 0. Memory contents are not reset.
  - Reset takes priority over clear and over all requests.
- Clear: clear=1 at a clock edge has the same effect as reset, except that r_data holds its value. Writes and reads in that cycle are discarded.
- Accept rules, evaluated from the registered state:
  - rd_acc = r_enable & !empty.
  - wr_acc = w_enable & (!full | rd_acc). A write into a full FIFO is accepted only when a read is accepted in the same cycle.
  - When empty, a simultaneous read and write accepts the write, rejects the read and sets underflow.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - mem[wr_ptr] <= w_data on wr_acc.
- Count: next count = count + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- Status flags are combinational decodes of the registered count, so they update on the edge after the accepting cycle.
- Error flags:
  - overflow is set when w_enable & !wr_acc.
  - underflow is set when r_enable & empty.
  - Both are sticky until clear or reset. Rejected operations do not change the pointers, the count or the memory.
- FWFT=0 read mode:
  - On rd_acc, r_data <= mem[rd_ptr], so data is valid one cycle after the read.
  - Otherwise r_data holds its last value.
- FWFT=1 read mode:
  - r_data = mem[rd_ptr] combinationally whenever !empty; r_data is 0 while empty.
  - r_enable pops the head word, and the next word appears in the same cycle that rd_ptr advances.
  - The first write into an empty FIFO is visible on r_data one cycle after the write edge. There is no write-to-read bypass.
- Wrap-around: continuous streaming over more than DEPTH words must preserve order. Pointer wrap does not affect count.
- Latency: the write-to-empty-deassert path is 1 cycle in both modes.

Test Plan (DEPTH=8, DATA_W=8, AF_THRESH=6, AE_THRESH=2 unless noted):
1. Reset mid-stream: write 5 words, then n_rst=0 for 1 cycle -> count=0, empty=1, almost_empty=1, full=0, r_data=0; a subsequent read sets underflow=1.
2. Fill and overflow: write 0x10..0x17 -> full=1 and count=8 after the 8th edge, almost_full=1 from count=6; a 9th write (0x18) sets overflow=1 and leaves count=8. Reading 8 words (FWFT=0) returns 0x10..0x17, each one cycle after its r_enable.
3. Simultaneous read and write: when full, write 0xAA with a read in the same cycle -> both accepted, count stays 8, overflow stays 0. When empty, the same stimulus -> write accepted, count=1, underflow=1.
4. Wrap-around stream: 20 words 0x00..0x13, with occupancy kept between 1 and 7 -> output order exact, no error flags, count matches a reference model every cycle.
5. Clear: with count=5 and overflow=1, pulse clear -> count=0, empty=1, overflow=0, and r_data unchanged.
6. FWFT=1: write 0x5A into an empty FIFO -> r_data=0x5A on the next cycle with no r_enable; write 0x5B, then pop -> r_data=0x5B in the same cycle; pop again -> empty=1 and r_data=0.

Source files
------------

// File: rtl/bulk_sync_fifo.sv
// Single-clock FIFO for the USB-to-SD bulk datapath: occupancy count, programmable
// almost-full/almost-empty, sticky overflow/underflow, flush, optional FWFT read.
module bulk_sync_fifo #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned AF_THRESH = 60,
   parameter int unsigned AE_THRESH = 4,
   parameter int unsigned FWFT      = 0
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     clear,
   input  logic                     w_enable,
   input  logic [DATA_W-1:0]        w_data,
   input  logic                     r_enable,
   output logic [DATA_W-1:0]        r_data,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AfC    = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AeC    = CNT_W'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, underflow_q;
   logic              rd_acc, wr_acc;

   always_comb begin
      empty        = (count_q == '0);
      full         = (count_q == DepthC);
      almost_full  = (count_q >= AfC);
      almost_empty = (count_q <= AeC);
      count        = count_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

   // A write into a full FIFO only fits if a pop frees a slot in the same cycle.
   always_comb begin
      rd_acc = r_enable & ~empty;
      wr_acc = w_enable & (~full | rd_acc);
   end

   always_comb begin
      count_d = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         end
         if (rd_acc) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         end
         count_q     <= count_d;
         overflow_q  <= overflow_q | (w_enable & ~wr_acc);
         underflow_q <= underflow_q | (r_enable & empty);
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (n_rst && !clear && wr_acc) begin
         mem[wr_ptr_q] <= w_data;
      end
   end

   if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] r_data_q;

      // Flush keeps the last word visible; only reset zeroes it.
      always_ff @(posedge clk) begin
         if (!n_rst) begin
            r_data_q <= '0;
         end else if (!clear && rd_acc) begin
            r_data_q <= mem[rd_ptr_q];
         end
      end

      assign r_data = r_data_q;
   end else begin : g_fwft_read
      assign r_data = empty ? '0 : mem[rd_ptr_q];
   end

endmodule

// File: tb/tb_bulk_sync_fifo.sv
// Directed bench for bulk_sync_fifo: one registered-read and one FWFT instance,
// DEPTH=8, DATA_W=8, AF_THRESH=6, AE_THRESH=2.
module tb_bulk_sync_fifo;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       a_clear, a_we, a_re;
   logic [7:0] a_wd, a_rd;
   logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic [3:0] a_count;
   logic       b_clear, b_we, b_re;
   logic [7:0] b_wd, b_rd;
   logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [3:0] b_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bulk_sync_fifo #(
      .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)
   ) u_reg (
      .clk(clk), .n_rst(n_rst), .clear(a_clear), .w_enable(a_we), .w_data(a_wd),
      .r_enable(a_re), .r_data(a_rd), .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
      .overflow(a_ovf), .underflow(a_unf)
   );

   bulk_sync_fifo #(
      .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)
   ) u_fwft (
      .clk(clk), .n_rst(n_rst), .clear(b_clear), .w_enable(b_we), .w_data(b_wd),
      .r_enable(b_re), .r_data(b_rd), .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
      .overflow(b_ovf), .underflow(b_unf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] q [$];
      logic [7:0] exp_rd;
      logic       we, re;
      int         nw;

      n_rst = 1'b0;
      a_clear = 1'b0; a_we = 1'b0; a_re = 1'b0; a_wd = '0;
      b_clear = 1'b0; b_we = 1'b0; b_re = 1'b0; b_wd = '0;
      step();
      step();
      n_rst = 1'b1;
      check("rst_count", a_count, 0);
      check("rst_empty", a_empty, 1);
      check("rst_ae", a_ae, 1);
      check("rst_full", a_full, 0);
      check("rst_af", a_af, 0);
      check("rst_ovf", a_ovf, 0);
      check("rst_unf", a_unf, 0);
      check("rst_rdata", a_rd, 0);
      check("rst_fwft_rdata", b_rd, 0);

      // 1: reset mid-stream
      for (int i = 0; i < 5; i++) begin
         a_we = 1'b1; a_wd = 8'(i + 1);
         step();
      end
      a_we = 1'b0;
      check("t1_count5", a_count, 5);
      check("t1_ae_low", a_ae, 0);
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      check("t1_rst_count", a_count, 0);
      check("t1_rst_empty", a_empty, 1);
      check("t1_rst_ae", a_ae, 1);
      check("t1_rst_full", a_full, 0);
      check("t1_rst_rdata", a_rd, 0);
      a_re = 1'b1;
      step();
      a_re = 1'b0;
      check("t1_unf", a_unf, 1);
      check("t1_unf_count", a_count, 0);
      a_clear = 1'b1;
      step();
      a_clear = 1'b0;
      check("t1_unf_cleared", a_unf, 0);

      // 2: fill, overflow, drain
      for (int k = 1; k <= 8; k++) begin
         a_we = 1'b1; a_wd = 8'(8'h0f + k);
         step();
         check("t2_fill_count", a_count, 64'(k));
         check("t2_fill_af", a_af, 64'(k >= 6));
         check("t2_fill_full", a_full, 64'(k == 8));
      end
      a_wd = 8'h18;
      step();
      a_we = 1'b0;
      check("t2_ovf", a_ovf, 1);
      check("t2_ovf_count", a_count, 8);
      for (int k = 0; k < 8; k++) begin
         a_re = 1'b1;
         step();
         check("t2_drain_data", a_rd, 64'(8'h10 + k));
      end
      a_re = 1'b0;
      check("t2_drained_empty", a_empty, 1);

      // 3: simultaneous read and write, full then empty
      a_clear = 1'b1;
      step();
      a_clear = 1'b0;
      for (int k = 0; k < 8; k++) begin
         a_we = 1'b1; a_wd = 8'(8'h20 + k);
         step();
      end
      check("t3_full", a_full, 1);
      a_we = 1'b1; a_wd = 8'haa; a_re = 1'b1;
      step();
      a_we = 1'b0;
      check("t3_full_rw_count", a_count, 8);
      check("t3_full_rw_ovf", a_ovf, 0);
      check("t3_full_rw_data", a_rd, 8'h20);
      for (int k = 1; k < 8; k++) begin
         step();
         check("t3_drain_data", a_rd, 64'(8'h20 + k));
      end
      step();
      a_re = 1'b0;
      check("t3_drain_aa", a_rd, 8'haa);
      check("t3_empty", a_empty, 1);
      a_we = 1'b1; a_wd = 8'hbb; a_re = 1'b1;
      step();
      a_we = 1'b0; a_re = 1'b0;
      check("t3_empty_rw_count", a_count, 1);
      check("t3_empty_rw_unf", a_unf, 1);
      check("t3_empty_rw_hold", a_rd, 8'haa);
      a_re = 1'b1;
      step();
      a_re = 1'b0;
      check("t3_read_bb", a_rd, 8'hbb);
      a_clear = 1'b1;
      step();
      a_clear = 1'b0;
      check("t3_clear_hold", a_rd, 8'hbb);

      // 4: wrap-around stream against a queue model
      exp_rd = 8'hbb;
      nw = 0;
      for (int cyc = 0; cyc < 100 && !(nw >= 20 && q.size() == 0); cyc++) begin
         we = (nw < 20);
         re = (q.size() >= 3 && (cyc % 4) != 3) || q.size() >= 6 || (nw >= 20 && q.size() > 0);
         a_we = we; a_wd = nw[7:0]; a_re = re;
         step();
         if (re) exp_rd = q.pop_front();
         if (we) begin
            q.push_back(nw[7:0]);
            nw++;
         end
         check("t4_count", a_count, 64'(q.size()));
         check("t4_data", a_rd, exp_rd);
      end
      a_we = 1'b0; a_re = 1'b0;
      check("t4_done", 64'(nw == 20 && q.size() == 0), 1);
      check("t4_empty", a_empty, 1);
      check("t4_ovf", a_ovf, 0);
      check("t4_unf", a_unf, 0);

      // 5: clear with count=5 and overflow set
      for (int k = 0; k < 9; k++) begin
         a_we = 1'b1; a_wd = 8'(8'h30 + k);
         step();
      end
      a_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_re = 1'b1;
         step();
      end
      a_re = 1'b0;
      check("t5_count5", a_count, 5);
      check("t5_ovf_set", a_ovf, 1);
      check("t5_rdata", a_rd, 8'h32);
      a_clear = 1'b1;
      step();
      a_clear = 1'b0;
      check("t5_clr_count", a_count, 0);
      check("t5_clr_empty", b_empty & a_empty, 1);
      check("t5_clr_ovf", a_ovf, 0);
      check("t5_clr_rdata", a_rd, 8'h32);

      // 6: first-word-fall-through instance
      check("t6_empty_rdata", b_rd, 0);
      b_we = 1'b1; b_wd = 8'h5a;
      step();
      b_we = 1'b0;
      check("t6_first_visible", b_rd, 8'h5a);
      check("t6_count1", b_count, 1);
      b_we = 1'b1; b_wd = 8'h5b;
      step();
      b_we = 1'b0;
      check("t6_head_held", b_rd, 8'h5a);
      b_re = 1'b1;
      step();
      check("t6_pop_next", b_rd, 8'h5b);
      step();
      b_re = 1'b0;
      check("t6_pop_empty", b_empty, 1);
      check("t6_pop_rdata0", b_rd, 0);
      check("t6_unf", b_unf, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
